// File: rtl/i2c_cfg_pkg.sv
// Shared types for the I2C register-table configuration sequencer.
// Holds the FSM encoding, the table end marker and the busy decode.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LATCH    = 4'd2,
    ST_ARM      = 4'd3,
    ST_START    = 4'd4,
    ST_WAIT_END = 4'd5,
    ST_CHECK    = 4'd6,
    ST_GAP      = 4'd7,
    ST_DONE     = 4'd8,
    ST_FAIL     = 4'd9
  } state_t;

  localparam logic [15:0] END_MARKER = 16'hFFFF;

  function automatic logic is_busy(input state_t st);
    logic busy_s;
    case (st)
      ST_IDLE, ST_DONE, ST_FAIL: busy_s = 1'b0;
      default:                   busy_s = 1'b1;
    endcase
    return busy_s;
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Register table storage: 64 x 16 bit, synchronous read with one cycle of latency.
// A write port lets the surrounding system load the table contents.
module i2c_cfg_rom (
  input  logic        iCLK,
  input  logic [5:0]  iADDR,
  output logic [15:0] oDATA,
  input  logic        iWE,
  input  logic [5:0]  iWADDR,
  input  logic [15:0] iWDATA
);

  logic [15:0] mem_r [64];
  logic [15:0] data_r;

  // table write port
  always_ff @(posedge iCLK) begin
    if (iWE) begin
      mem_r[iWADDR] <= iWDATA;
    end
  end

  // registered read, data valid the cycle after the address
  always_ff @(posedge iCLK) begin
    data_r <= mem_r[iADDR];
  end

  assign oDATA = data_r;

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks a register table and issues one two-byte I2C write per entry,
// retrying NACKed entries and spacing transactions by an idle gap.
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int         TABLE_LEN  = 16,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 1000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iGO,
  output logic [5:0]  oTAB_ADDR,
  input  logic [15:0] iTAB_DATA,
  output logic        oSTART,
  output logic        oREAD,
  output logic [6:0]  oADDR,
  output logic        oWLEN,
  output logic [7:0]  oWDATA1,
  output logic [7:0]  oWDATA2,
  input  logic        iEND,
  input  logic        iACK,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic [5:0]  oERR_IDX
);

  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       TAB_END   = 7'(TABLE_LEN);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  state_t           state_r, state_s;
  logic [5:0]       index_r, index_s;
  logic [3:0]       retry_r, retry_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic [7:0]       wdata1_r, wdata1_s, wdata2_r, wdata2_s;
  logic [5:0]       err_idx_r, err_idx_s;
  logic             start_r, busy_r, done_r, err_r;
  logic [6:0]       idx_inc_s;
  logic [3:0]       retry_inc_s;

  // next-state and datapath update
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    retry_s     = retry_r;
    gap_s       = gap_r;
    wdata1_s    = wdata1_r;
    wdata2_s    = wdata2_r;
    err_idx_s   = err_idx_r;
    idx_inc_s   = {1'b0, index_r} + 7'd1;
    retry_inc_s = retry_r + 4'd1;
    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (iGO) begin
          state_s = ST_FETCH;
          index_s = 6'd0;
          retry_s = 4'd0;
          gap_s   = {GAP_W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: state_s = ST_LATCH;
      ST_LATCH: begin
        if (iTAB_DATA == END_MARKER) begin
          state_s = ST_DONE;
        end else begin
          wdata1_s = iTAB_DATA[15:8];
          wdata2_s = iTAB_DATA[7:0];
          state_s  = ST_ARM;
        end
      end
      // never raise start while the master is still busy
      ST_ARM: begin
        if (iEND) state_s = ST_START;
        else      state_s = ST_ARM;
      end
      ST_START: begin
        if (!iEND) state_s = ST_WAIT_END;
        else       state_s = ST_START;
      end
      ST_WAIT_END: begin
        if (iEND) state_s = ST_CHECK;
        else      state_s = ST_WAIT_END;
      end
      ST_CHECK: begin
        gap_s = {GAP_W{1'b0}};
        if (!iACK) begin
          retry_s = 4'd0;
          if (idx_inc_s == TAB_END) begin
            state_s = ST_DONE;
            // a full 64-entry table stops at 63 instead of wrapping
            index_s = idx_inc_s[6] ? index_r : idx_inc_s[5:0];
          end else begin
            state_s = ST_GAP;
            index_s = idx_inc_s[5:0];
          end
        end else begin
          retry_s = retry_inc_s;
          if (retry_inc_s == RETRY_LIM) begin
            state_s   = ST_FAIL;
            err_idx_s = index_r;
          end else begin
            state_s = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = ST_FETCH;
          gap_s   = {GAP_W{1'b0}};
        end else begin
          gap_s = gap_r + GAP_W'(1);
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // state and registered outputs; flags decode the next state so they align with state_r
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r   <= ST_IDLE;
      index_r   <= 6'd0;
      retry_r   <= 4'd0;
      gap_r     <= {GAP_W{1'b0}};
      wdata1_r  <= 8'd0;
      wdata2_r  <= 8'd0;
      err_idx_r <= 6'd0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      index_r   <= index_s;
      retry_r   <= retry_s;
      gap_r     <= gap_s;
      wdata1_r  <= wdata1_s;
      wdata2_r  <= wdata2_s;
      err_idx_r <= err_idx_s;
      start_r   <= (state_s == ST_START);
      busy_r    <= is_busy(state_s);
      done_r    <= (state_s == ST_DONE);
      err_r     <= (state_s == ST_FAIL);
    end
  end

  assign oTAB_ADDR = index_r;
  assign oSTART    = start_r;
  assign oREAD     = 1'b0;
  assign oADDR     = DEV_ADDR;
  assign oWLEN     = 1'b1;
  assign oWDATA1   = wdata1_r;
  assign oWDATA2   = wdata2_r;
  assign oBUSY     = busy_r;
  assign oDONE     = done_r;
  assign oERR      = err_r;
  assign oERR_IDX  = err_idx_r;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq with a behavioural byte master and table-driven scenarios.
module tb_i2c_cfg_seq;

  localparam int G = 4;  // gap cycles
  localparam int B = 3;  // master busy cycles per transfer

  logic        clk = 1'b0;
  logic        rst, go, we;
  logic [5:0]  tab_addr, waddr, err_idx;
  logic [15:0] tab_data, wdata;
  logic        start, rd, wlen, iend, iack, busy, done, err;
  logic [6:0]  addr;
  logic [7:0]  wd1, wd2;

  always #5 clk = ~clk;

  i2c_cfg_rom u_rom (
    .iCLK(clk), .iADDR(tab_addr), .oDATA(tab_data),
    .iWE(we), .iWADDR(waddr), .iWDATA(wdata)
  );

  i2c_cfg_seq #(.TABLE_LEN(3), .DEV_ADDR(7'h1A), .MAX_RETRY(3), .GAP_CYCLES(G)) dut (
    .iCLK(clk), .iRST(rst), .iGO(go), .oTAB_ADDR(tab_addr), .iTAB_DATA(tab_data),
    .oSTART(start), .oREAD(rd), .oADDR(addr), .oWLEN(wlen),
    .oWDATA1(wd1), .oWDATA2(wd2), .iEND(iend), .iACK(iack),
    .oBUSY(busy), .oDONE(done), .oERR(err), .oERR_IDX(err_idx)
  );

  typedef struct packed {
    logic [2:0][15:0] tab;
    logic [2:0][3:0]  nack;
    logic [3:0]       ntx;
    logic [4:0][15:0] tx;
    logic             done;
    logic             err;
    logic [5:0]       err_idx;
    logic [5:0]       fidx;
  } vec_t;

  vec_t        vecs [7];
  int          checks = 0, errors = 0;
  logic [15:0] tx_q [$];
  int          nack_left [3];
  int          cnt = 0, hold_cnt = 0, cyc = 0, last_end_cyc = 0;
  bit          armed = 1'b0;
  int          gap_err = 0, bus_err = 0, early_start = 0;
  logic        start_prev = 1'b0;

  // byte master: accepts a start while idle, stays busy B cycles, answers ACK/NACK
  initial begin
    iend = 1'b1;
    iack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !start_prev && !iend) early_start++;
      if (start && !start_prev && armed) begin
        if (cyc - last_end_cyc != G + 5) gap_err++;
        armed = 1'b0;
      end
      start_prev = start;
      if (hold_cnt > 0) begin
        hold_cnt--;
        cnt  = 0;
        iend = (hold_cnt == 0);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          iend = 1'b1;
          last_end_cyc = cyc;
          armed = 1'b1;
        end
      end else if (iend && start) begin
        tx_q.push_back({wd1, wd2});
        if (addr !== 7'h1A || rd !== 1'b0 || wlen !== 1'b1) bus_err++;
        if (tab_addr < 6'd3 && nack_left[tab_addr] > 0) begin
          iack = 1'b1;
          nack_left[tab_addr]--;
        end else begin
          iack = 1'b0;
        end
        iend = 1'b0;
        cnt  = B;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] t0, t1, t2, input logic [3:0] n0, n1, n2,
                              input logic [3:0] ntx, input logic [15:0] x0, x1, x2, x3, x4,
                              input logic d, e, input logic [5:0] ei, fi);
    vec_t v;
    v.tab[0] = t0; v.tab[1] = t1; v.tab[2] = t2;
    v.nack[0] = n0; v.nack[1] = n1; v.nack[2] = n2;
    v.ntx = ntx;
    v.tx[0] = x0; v.tx[1] = x1; v.tx[2] = x2; v.tx[3] = x3; v.tx[4] = x4;
    v.done = d; v.err = e; v.err_idx = ei; v.fidx = fi;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 6'(i); wdata = v.tab[i];
      nack_left[i] = int'(v.nack[i]);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    tx_q.delete();
    armed = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " idle timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_result(input string nm, input vec_t v);
    chk({nm, " tx count"}, 32'(tx_q.size()), 32'(v.ntx));
    for (int i = 0; i < int'(v.ntx); i++) begin
      if (i < tx_q.size()) chk($sformatf("%s tx%0d", nm, i), 32'(tx_q[i]), 32'(v.tx[i]));
    end
    chk({nm, " done"}, 32'(done), 32'(v.done));
    chk({nm, " err"}, 32'(err), 32'(v.err));
    if (v.err) chk({nm, " err_idx"}, 32'(err_idx), 32'(v.err_idx));
    chk({nm, " index"}, 32'(tab_addr), 32'(v.fidx));
    chk({nm, " gap"}, 32'(gap_err), 32'd0);
    chk({nm, " bus fields"}, 32'(bus_err), 32'd0);
    chk({nm, " start while busy"}, 32'(early_start), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = mk(16'h0F00, 16'h0405, 16'h0812, 4'd0, 4'd0, 4'd0, 4'd3,
                 16'h0F00, 16'h0405, 16'h0812, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd0, 6'd3);
    vecs[1] = mk(16'h0F00, 16'hFFFF, 16'h0812, 4'd0, 4'd0, 4'd0, 4'd1,
                 16'h0F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd0, 6'd1);
    vecs[2] = mk(16'h0F00, 16'h0405, 16'h0812, 4'd0, 4'd0, 4'd2, 4'd5,
                 16'h0F00, 16'h0405, 16'h0812, 16'h0812, 16'h0812, 1'b1, 1'b0, 6'd0, 6'd3);
    vecs[3] = mk(16'h0F00, 16'h0405, 16'h0812, 4'd0, 4'd15, 4'd0, 4'd4,
                 16'h0F00, 16'h0405, 16'h0405, 16'h0405, 16'h0000, 1'b0, 1'b1, 6'd1, 6'd1);
    vecs[4] = mk(16'hFFFF, 16'h0405, 16'h0812, 4'd0, 4'd0, 4'd0, 4'd0,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd0, 6'd0);
    vecs[5] = mk(16'hA55A, 16'h0102, 16'h7F80, 4'd3, 4'd0, 4'd0, 4'd3,
                 16'hA55A, 16'hA55A, 16'hA55A, 16'h0000, 16'h0000, 1'b0, 1'b1, 6'd0, 6'd0);
    vecs[6] = mk(16'hA55A, 16'h0102, 16'h7F80, 4'd0, 4'd1, 4'd0, 4'd4,
                 16'hA55A, 16'h0102, 16'h0102, 16'h7F80, 16'h0000, 1'b1, 1'b0, 6'd0, 6'd3);

    rst = 1'b1; go = 1'b0; we = 1'b0; waddr = 6'd0; wdata = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset start", 32'(start), 32'd0);
    chk("reset busy/done/err", 32'({busy, done, err}), 32'd0);
    chk("reset err_idx/index", 32'({err_idx, tab_addr}), 32'd0);
    chk("reset wdata", 32'({wd1, wd2}), 32'd0);
    chk("fixed bus fields", 32'({addr, rd, wlen}), 32'({7'h1A, 1'b0, 1'b1}));

    for (int v = 0; v < 7; v++) begin
      load(vecs[v]);
      start_run();
      chk($sformatf("vec%0d busy after go", v), 32'(busy), 32'd1);
      wait_idle($sformatf("vec%0d", v));
      check_result($sformatf("vec%0d", v), vecs[v]);
    end

    // reset while the master is mid-transfer and holds iEND low for 50 cycles
    load(vecs[0]);
    start_run();
    n = 0;
    while (tx_q.size() < 1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst-mid first tx", 32'(tx_q.size()), 32'd1);
    @(negedge clk);
    hold_cnt = 50; rst = 1'b1; tx_q.delete(); armed = 1'b0;
    @(negedge clk);
    rst = 1'b0; go = 1'b1;
    chk("rst-mid outputs", 32'({start, busy, done, err, tab_addr}), 32'd0);
    @(negedge clk);
    go = 1'b0;
    wait_idle("rst-mid");
    check_result("rst-mid", vecs[0]);

    // go pulsed during the inter-transaction gap must be ignored
    load(vecs[0]);
    start_run();
    n = 0;
    while (!(tx_q.size() >= 1 && iend) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gap-go first end", 32'(tx_q.size()), 32'd1);
    @(negedge clk);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    go = 1'b0;
    wait_idle("gap-go");
    check_result("gap-go", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 SHALL have parameter TABLE_LEN, 16, number of table entries (1..64).
REQ-002 SHALL have parameter DEV_ADDR, 7'h1A, 7-bit I2C target address.
REQ-003 SHALL have parameter MAX_RETRY, 3, attempts per entry before failing (1..15).
REQ-004 SHALL have parameter GAP_CYCLES, 1000, idle iCLK cycles between transactions (>=1).
REQ-005 SHALL have ports: iCLK in 1 clock; iRST in 1 reset; iGO in 1 start-sequence pulse; oTAB_ADDR out 6 table index; iTAB_DATA in 16 table entry {reg[15:8], val[7:0]}.
REQ-006 SHALL have ports to the byte master: oSTART out 1; oREAD out 1 (tied 0); oADDR out 7 (=DEV_ADDR); oWLEN out 1 (tied 1); oWDATA1 out 8; oWDATA2 out 8; iEND in 1 (1 = master idle); iACK in 1 (1 = NACK seen).
REQ-007 SHALL have status ports: oBUSY out 1; oDONE out 1; oERR out 1; oERR_IDX out 6.
REQ-008 SHALL use one clock, iCLK; iRST SHALL be synchronous and active-high.

Function
REQ-009 SHALL implement states IDLE, FETCH, LATCH, ARM, START, WAIT_END, CHECK, GAP, DONE, FAIL.
REQ-010 IDLE/DONE/FAIL: iGO=1 SHALL clear oDONE, oERR, index and retry count, then enter FETCH next cycle; iGO SHALL be ignored in all other states.
REQ-011 FETCH SHALL drive oTAB_ADDR=index; the external table is synchronous with exactly 1-cycle latency; LATCH SHALL capture iTAB_DATA.
REQ-012 A captured entry of 16'hFFFF SHALL be an end marker: enter DONE without any bus transaction.
REQ-013 Otherwise LATCH SHALL load oWDATA1=entry[15:8], oWDATA2=entry[7:0] and enter ARM; the WDATA outputs SHALL stay stable until the next LATCH.
REQ-014 ARM SHALL hold oSTART=0 until iEND=1 is sampled, then enter START.
REQ-015 START SHALL drive oSTART=1 until iEND=0 is sampled, then enter WAIT_END with oSTART=0 (oSTART high >=1 cycle, one rising edge per attempt).
REQ-016 WAIT_END SHALL wait for iEND=1, then enter CHECK; no timeout.
REQ-017 CHECK with iACK=0: index+1, retry count cleared; if new index==TABLE_LEN enter DONE, else GAP.
REQ-018 CHECK with iACK=1: retry count+1; if new count==MAX_RETRY enter FAIL with oERR=1, oERR_IDX=index; else GAP, then re-issue the same entry (index unchanged).
REQ-019 GAP SHALL count exactly GAP_CYCLES cycles, then enter FETCH.
REQ-020 oBUSY SHALL be 1 in every state except IDLE, DONE, FAIL; oDONE=1 only in DONE; oERR=1 only in FAIL.
REQ-021 Index counter SHALL be 6 bits, never exceed TABLE_LEN, and never wrap.

Reset
REQ-022 iRST SHALL force state IDLE, oSTART=0, oBUSY=0, oDONE=0, oERR=0, oERR_IDX=0, oTAB_ADDR=0, oWDATA1=0, oWDATA2=0, index=0, retry=0, gap counter=0.
REQ-023 Reset mid-transaction SHALL NOT wait for the master; a following iGO SHALL go through ARM so no start is issued while iEND=0.

Structure
REQ-024 Package i2c_cfg_pkg SHALL hold the state enum and END_MARKER=16'hFFFF.
REQ-025 Table storage SHALL be a separate module i2c_cfg_rom (sync read, 1-cycle latency), instantiated by the parent alongside i2c_cfg_seq; i2c_cfg_seq SHALL contain no sub-modules.

Verification
REQ-026 TABLE_LEN=3, entries {0x0F00,0x0405,0x0812}, model ACKs all -> three writes addr 0x1A with those byte pairs in order, GAP_CYCLES between, oDONE=1, oERR=0.
REQ-027 Entry 1 = 16'hFFFF -> exactly one write (entry 0), DONE with index 1.
REQ-028 Model NACKs entry 2 twice then ACKs, MAX_RETRY=3 -> entry 2 sent 3 times, sequence completes, oERR=0.
REQ-029 Model NACKs entry 1 always, MAX_RETRY=3 -> 3 attempts, FAIL, oERR=1, oERR_IDX=1, no write of entry 2.
REQ-030 iRST asserted during WAIT_END while model holds iEND=0 for 50 cycles, iGO next cycle -> oSTART stays 0 until iEND=1, then entry 0 re-sent.
REQ-031 iGO pulsed during GAP -> ignored; sequence output identical to REQ-026.
